// File: rtl/uart_rx_in_pkg.sv
// Shared definitions for the uart_rx_in serial receiver: FSM encoding and frame geometry.
// Optional even-parity support is selected by the UART_RX_PARITY_EN macro.
package uart_rx_in_pkg;

    localparam int UART_CLK_DIV_DEFAULT = 16;
    localparam int UART_DATA_W_DEFAULT  = 8;

`ifdef UART_RX_PARITY_EN
    localparam int UART_PARITY_BITS = 1;
`else
    localparam int UART_PARITY_BITS = 0;
`endif

    // start + data + optional parity + stop
    function automatic int uart_frame_bits(input int data_w);
        return 1 + data_w + UART_PARITY_BITS + 1;
    endfunction

    localparam int UART_FRAME_BITS = uart_frame_bits(UART_DATA_W_DEFAULT);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd3,
        ST_BREAK  = 3'd4,
        ST_PARITY = 3'd5
    } uart_state_t;

endpackage

// File: rtl/uart_rx_in_if.sv
// Receiver-to-input-module bus: received byte, write strobe and status.
// perr exists only when UART_RX_PARITY_EN is defined.
interface uart_rx_in_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] odata;
    logic              we;
    logic              ferr;
    logic              busy;
`ifdef UART_RX_PARITY_EN
    logic              perr;
`endif

    modport master (
        output odata,
        output we,
        output ferr,
`ifdef UART_RX_PARITY_EN
        output perr,
`endif
        output busy
    );

    modport slave (
        input odata,
        input we,
        input ferr,
`ifdef UART_RX_PARITY_EN
        input perr,
`endif
        input busy
    );

endinterface

// File: rtl/uart_rx_in_bit_timer.sv
// Bit-period divider: loads half a bit period on a start edge, then ticks once per full bit.
// The tick lands in the middle of each serial bit.
module uart_bit_timer #(
    parameter int CLK_DIV = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load_half,
    input  logic i_run,
    output logic o_tick
);

    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_cnt;

    // NOTE: synchronous reset lives inside the clocked block, and state uses <= only.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load_half) begin
            r_cnt <= HALF_LOAD;
        end else if (i_run) begin
            if (r_cnt == '0) begin
                r_cnt <= FULL_LOAD;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign o_tick = i_run && !i_load_half && (r_cnt == '0);

endmodule

// File: rtl/uart_rx_in.sv
// 8N1 serial receiver feeding the CPU input module's idata/we pins.
// Define UART_RX_PARITY_EN to insert an even-parity bit before stop and add bus.perr.
module uart_rx_in
    import uart_rx_in_pkg::*;
#(
    parameter int CLK_DIV = UART_CLK_DIV_DEFAULT,
    parameter int DATA_W  = UART_DATA_W_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rxd,
    uart_rx_in_if.master  bus
);

    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic              r_sync1;
    logic              r_sync2;
    uart_state_t       r_state;
    logic [BW-1:0]     r_bitcnt;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] r_odata;
    logic              r_we;
    logic              r_ferr;
    logic              r_busy;
`ifdef UART_RX_PARITY_EN
    logic              r_par;
    logic              r_perr;
`endif

    logic w_rxd_s;
    logic w_load_half;
    logic w_run;
    logic w_tick;

    // Two-flop synchronizer; resets to the idle line level so reset never fakes a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rxd;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rxd_s     = r_sync2;
    assign w_load_half = (r_state == ST_IDLE) && !w_rxd_s;
    assign w_run       = (r_state == ST_START) || (r_state == ST_DATA) ||
                         (r_state == ST_PARITY) || (r_state == ST_STOP);

    uart_bit_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_bit_timer (
        .clk         (clk),
        .rst         (rst),
        .i_load_half (w_load_half),
        .i_run       (w_run),
        .o_tick      (w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_odata  <= '0;
            r_we     <= 1'b0;
            r_ferr   <= 1'b0;
            r_busy   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par    <= 1'b0;
            r_perr   <= 1'b0;
`endif
        end else begin
            r_we   <= 1'b0;
            r_ferr <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_perr <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (!w_rxd_s) begin
                        r_state <= ST_START;
                        r_busy  <= 1'b1;
                    end
                end

                ST_START: begin
                    if (w_tick) begin
                        if (w_rxd_s) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state  <= ST_DATA;
                            r_bitcnt <= '0;
                        end
                    end
                end

                ST_DATA: begin
                    if (w_tick) begin
                        // LSB arrives first, so shifting in from the top leaves it at bit 0.
                        r_shift <= {w_rxd_s, r_shift[DATA_W-1:1]};
                        if (r_bitcnt == BW'(DATA_W - 1)) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= ST_PARITY;
`else
                            r_state <= ST_STOP;
`endif
                        end else begin
                            r_bitcnt <= r_bitcnt + 1'b1;
                        end
                    end
                end

`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (w_tick) begin
                        r_par   <= w_rxd_s;
                        r_state <= ST_STOP;
                    end
                end
`endif

                ST_STOP: begin
                    if (w_tick) begin
                        if (w_rxd_s) begin
`ifdef UART_RX_PARITY_EN
                            if ((^r_shift) ^ r_par) begin
                                r_perr <= 1'b1;
                            end else begin
                                r_odata <= r_shift;
                                r_we    <= 1'b1;
                            end
`else
                            r_odata <= r_shift;
                            r_we    <= 1'b1;
`endif
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_ferr  <= 1'b1;
                            r_state <= ST_BREAK;
                        end
                    end
                end

                // A line held low after a bad stop must go high before a new start is accepted.
                ST_BREAK: begin
                    if (w_rxd_s) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.odata = r_odata;
    assign bus.we    = r_we;
    assign bus.ferr  = r_ferr;
    assign bus.busy  = r_busy;
`ifdef UART_RX_PARITY_EN
    assign bus.perr  = r_perr;
`endif

endmodule

// File: tb/tb_uart_rx_in.sv
// Directed bench for uart_rx_in: latency, back-to-back frames, glitch, break, mid-frame reset.
// Parity cases run only when UART_RX_PARITY_EN is defined.
module tb_uart_rx_in;
    import uart_rx_in_pkg::*;

    localparam int CLK_DIV = 16;
    localparam int DATA_W  = 8;
    localparam int LAT     = CLK_DIV / 2 + (UART_FRAME_BITS - 1) * CLK_DIV + 3;
    localparam int FRAME   = UART_FRAME_BITS * CLK_DIV;

    logic clk;
    logic rst;
    logic rxd;
    int   cyc;

    uart_rx_in_if #(.DATA_W(DATA_W)) bus ();

    uart_rx_in #(
        .CLK_DIV (CLK_DIV),
        .DATA_W  (DATA_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .rxd (rxd),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_total = 0;
    int         n_bad   = 0;
    int         we_cyc[$];
    logic [7:0] we_dat[$];
    int         ferr_cnt;
    int         perr_cnt;
    int         both_cnt;
    int         busy_run;
    int         busy_max;
    int         busy_fall;
    logic       prev_busy;

    initial begin
        ferr_cnt = 0; perr_cnt = 0; both_cnt = 0;
        busy_run = 0; busy_max = 0; busy_fall = -1; prev_busy = 1'b0;
    end

    always @(negedge clk) begin
        if (bus.we) begin
            we_cyc.push_back(cyc);
            we_dat.push_back(bus.odata);
        end
        if (bus.ferr) ferr_cnt++;
        if (bus.we && bus.ferr) both_cnt++;
`ifdef UART_RX_PARITY_EN
        if (bus.perr) perr_cnt++;
`endif
        if (bus.busy) begin
            busy_run++;
            if (busy_run > busy_max) busy_max = busy_run;
        end else begin
            busy_run = 0;
        end
        if (prev_busy && !bus.busy) busy_fall = cyc;
        prev_busy = bus.busy;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        we_cyc.delete();
        we_dat.delete();
        ferr_cnt = 0;
        perr_cnt = 0;
        busy_max = 0;
        busy_fall = -1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic b);
        rxd = b;
        idle(CLK_DIV);
    endtask

    // Sends one frame; par_flip inverts the even-parity bit when parity is built in.
    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_flip,
                              output int fall);
        fall = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < DATA_W; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^d) ^ par_flip);
`else
        if (par_flip) rxd = 1'b1;
`endif
        drive_bit(stop_b);
        rxd = 1'b1;
    endtask

    int f0, f1, f2;
    logic [7:0] bits_a5;

    initial begin
        rst = 1'b1;
        rxd = 1'b1;
        bits_a5 = 8'hA5;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_odata", 32'(bus.odata), 32'h0);
        check("rst_we",    32'(bus.we),    32'h0);
        check("rst_ferr",  32'(bus.ferr),  32'h0);
        check("rst_busy",  32'(bus.busy),  32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        idle(10);

        // Single frame 0x41
        clear_log();
        send_frame(8'h41, 1'b1, 1'b0, f0);
        idle(10);
        check("a_we_count", 32'(we_cyc.size()), 32'd1);
        if (we_cyc.size() == 1) begin
            check("a_latency",   32'(we_cyc[0] - f0), 32'(LAT));
            check("a_data",      32'(we_dat[0]),      32'h41);
            check("a_busy_fall", 32'(busy_fall),      32'(we_cyc[0]));
        end
        check("a_ferr",  32'(ferr_cnt),   32'd0);
        check("a_odata", 32'(bus.odata),  32'h41);

        // Back-to-back 0x42 0x43 0x44, zero idle bits
        clear_log();
        send_frame(8'h42, 1'b1, 1'b0, f0);
        send_frame(8'h43, 1'b1, 1'b0, f1);
        send_frame(8'h44, 1'b1, 1'b0, f2);
        idle(20);
        check("b_we_count", 32'(we_cyc.size()), 32'd3);
        if (we_cyc.size() == 3) begin
            check("b_lat0",  32'(we_cyc[0] - f0),        32'(LAT));
            check("b_gap01", 32'(we_cyc[1] - we_cyc[0]), 32'(FRAME));
            check("b_gap12", 32'(we_cyc[2] - we_cyc[1]), 32'(FRAME));
            check("b_d0",    32'(we_dat[0]), 32'h42);
            check("b_d1",    32'(we_dat[1]), 32'h43);
            check("b_d2",    32'(we_dat[2]), 32'h44);
        end

        // Glitch: 5 low cycles
        clear_log();
        rxd = 1'b0;
        idle(5);
        rxd = 1'b1;
        idle(40);
        check("g_we_count", 32'(we_cyc.size()),   32'd0);
        check("g_ferr",     32'(ferr_cnt),        32'd0);
        check("g_busy_le8", 32'(busy_max <= 8),   32'd1);
        check("g_busy_seen",32'(busy_max > 0),    32'd1);
        check("g_busy_end", 32'(bus.busy),        32'd0);

        // Break: 0x55 with low stop, line held low 40 more cycles
        clear_log();
        send_frame(8'h55, 1'b0, 1'b0, f0);
        rxd = 1'b0;
        idle(40);
        check("k_busy_held", 32'(bus.busy), 32'd1);
        rxd = 1'b1;
        idle(30);
        check("k_ferr_count", 32'(ferr_cnt),        32'd1);
        check("k_we_count",   32'(we_cyc.size()),   32'd0);
        check("k_odata",      32'(bus.odata),       32'h44);
        check("k_busy_end",   32'(bus.busy),        32'd0);
        clear_log();
        send_frame(8'h44, 1'b1, 1'b0, f0);
        idle(10);
        check("k_after_count", 32'(we_cyc.size()), 32'd1);
        if (we_cyc.size() == 1) check("k_after_data", 32'(we_dat[0]), 32'h44);

        // Reset during bit 4 of 0xA5
        clear_log();
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(bits_a5[i]);
        rxd = bits_a5[4];
        idle(8);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("r_odata", 32'(bus.odata), 32'h0);
        check("r_busy",  32'(bus.busy),  32'h0);
        check("r_we",    32'(bus.we),    32'h0);
        @(posedge clk);
        #1;
        rxd = 1'b1;
        rst = 1'b0;
        idle(20);
        check("r_we_count", 32'(we_cyc.size()), 32'd0);
        check("r_ferr",     32'(ferr_cnt),      32'd0);
        send_frame(8'h5A, 1'b1, 1'b0, f0);
        idle(10);
        check("r_next_count", 32'(we_cyc.size()), 32'd1);
        if (we_cyc.size() == 1) begin
            check("r_next_data", 32'(we_dat[0]),      32'h5A);
            check("r_next_lat",  32'(we_cyc[0] - f0), 32'(LAT));
        end

`ifdef UART_RX_PARITY_EN
        clear_log();
        send_frame(8'h41, 1'b1, 1'b0, f0);
        idle(10);
        check("p_good_count", 32'(we_cyc.size()), 32'd1);
        check("p_good_odata", 32'(bus.odata),     32'h41);
        check("p_good_perr",  32'(perr_cnt),      32'd0);
        clear_log();
        send_frame(8'h41, 1'b1, 1'b1, f0);
        idle(10);
        check("p_bad_perr",  32'(perr_cnt),      32'd1);
        check("p_bad_we",    32'(we_cyc.size()), 32'd0);
        check("p_bad_ferr",  32'(ferr_cnt),      32'd0);
`endif

        check("we_ferr_excl", 32'(both_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
